// File: rtl/reg_rmw_bram_pkg.sv
// Shared definitions for the reg_rmw_bram register-array extern.
//   - op-code width and encodings presented on in_op
//   - control FSM state encoding (post-reset init sweep, then normal service)
package reg_rmw_bram_pkg;

    localparam int OP_W = 2;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP   = 2'b00;
    localparam op_t OP_READ  = 2'b01;
    localparam op_t OP_WRITE = 2'b10;
    localparam op_t OP_ADD   = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/reg_rmw_bram_sdp_bram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output. No reset on the storage or the read register. Read-first: a read
// and a write to the same address on the same edge return the old contents.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address (AW bits)
//   wdata  write data (DW bits)
//   raddr  read address (AW bits), data appears on rdata after one edge
//   rdata  registered read data (DW bits)
module reg_rmw_bram_sdp_bram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/reg_rmw_bram.sv
// Register-array extern for stateful data-path actions: fixed-latency
// READ / WRITE / ADD (fetch-and-add) on a block-RAM array, one request per
// cycle, with forwarding so same-address back-to-back requests behave
// strictly sequentially. After every reset the array is swept to INIT_VAL
// before requests are accepted.
// Ports:
//   clk        clock
//   resetn     asynchronous active-low reset
//   in_valid   request present
//   in_ready   requests accepted (low during the init sweep)
//   in_op      00 NOP, 01 READ, 10 WRITE, 11 ADD
//   in_addr    entry index (L2_DEPTH bits)
//   in_data    write value / addend (WIDTH bits)
//   out_valid  one-cycle response pulse, two cycles after acceptance
//   out_data   old value (RET_NEW=0) or new value (RET_NEW=1); holds otherwise
//   init_done  init sweep complete
module reg_rmw_bram
    import reg_rmw_bram_pkg::*;
#(
    parameter int               L2_DEPTH = 8,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter bit               RET_NEW  = 1'b0,
    parameter bit               SAT_ADD  = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [L2_DEPTH-1:0] in_addr,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic                init_done
);

    state_t state_reg, state_next;
    logic [L2_DEPTH-1:0] sweep_addr_reg;

    // Stage 1: request accepted on the previous edge, RAM data now valid.
    logic                s1_valid_reg;
    op_t                 s1_op_reg;
    logic [L2_DEPTH-1:0] s1_addr_reg;
    logic [WIDTH-1:0]    s1_data_reg;

    // Copy of the RAM write performed on the previous edge. The RAM is
    // read-first, so that write is invisible to a read issued on the same edge.
    logic                fwd_valid_reg;
    logic [L2_DEPTH-1:0] fwd_addr_reg;
    logic [WIDTH-1:0]    fwd_data_reg;

    logic                out_valid_reg;
    logic [WIDTH-1:0]    out_data_reg;

    logic                accept;
    logic [WIDTH-1:0]    ram_rdata;
    logic                ram_we;
    logic [L2_DEPTH-1:0] ram_waddr;
    logic [WIDTH-1:0]    ram_wdata;
    logic [WIDTH-1:0]    old_val;
    logic [WIDTH-1:0]    new_val;
    logic [WIDTH:0]      sum;

    assign in_ready  = (state_reg == ST_RUN);
    assign init_done = (state_reg == ST_RUN);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    // NOPs are accepted but never enter the pipeline.
    assign accept = in_valid && in_ready && (in_op != OP_NOP);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: if (&sweep_addr_reg) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    assign old_val = (fwd_valid_reg && (fwd_addr_reg == s1_addr_reg)) ? fwd_data_reg : ram_rdata;
    assign sum     = {1'b0, old_val} + {1'b0, s1_data_reg};

    always_comb begin
        new_val = old_val;
        case (s1_op_reg)
            OP_WRITE: new_val = s1_data_reg;
            OP_ADD:   new_val = (SAT_ADD && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            default:  new_val = old_val;
        endcase
    end

    // The sweep owns the write port in INIT; afterwards stage 1 writes back.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_addr_reg;
        ram_wdata = new_val;
        if (state_reg == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_addr_reg;
            ram_wdata = INIT_VAL;
        end else begin
            ram_we = s1_valid_reg && ((s1_op_reg == OP_WRITE) || (s1_op_reg == OP_ADD));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_INIT;
            sweep_addr_reg <= '0;
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= OP_NOP;
            s1_addr_reg    <= '0;
            s1_data_reg    <= '0;
            fwd_valid_reg  <= 1'b0;
            fwd_addr_reg   <= '0;
            fwd_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                sweep_addr_reg <= sweep_addr_reg + 1'b1;
            end
            s1_valid_reg <= accept;
            if (accept) begin
                s1_op_reg   <= in_op;
                s1_addr_reg <= in_addr;
                s1_data_reg <= in_data;
            end
            fwd_valid_reg <= ram_we;
            fwd_addr_reg  <= ram_waddr;
            fwd_data_reg  <= ram_wdata;
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg <= RET_NEW ? new_val : old_val;
            end
        end
    end

    reg_rmw_bram_sdp_bram #(
        .AW (L2_DEPTH),
        .DW (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (in_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_reg_rmw_bram.sv
module tb_reg_rmw_bram;
    import reg_rmw_bram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    // Main instance: 16 entries x 16 bits, INIT_VAL 5, returns old value, wraps.
    logic        in_valid;
    logic [1:0]  in_op;
    logic [3:0]  in_addr;
    logic [15:0] in_data;
    logic        in_ready, out_valid, init_done;
    logic [15:0] out_data;

    // Two 8-bit instances (saturating / wrapping, RET_NEW=1) sharing one bus.
    logic        b_valid;
    logic [1:0]  b_op;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;
    logic        s_ready, s_ovalid, s_done;
    logic [7:0]  s_odata;
    logic        w_ready, w_ovalid, w_done;
    logic [7:0]  w_odata;

    reg_rmw_bram #(.L2_DEPTH(4), .WIDTH(16), .INIT_VAL(16'd5), .RET_NEW(1'b0), .SAT_ADD(1'b0)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .init_done(init_done));

    reg_rmw_bram #(.L2_DEPTH(4), .WIDTH(8), .INIT_VAL(8'd0), .RET_NEW(1'b1), .SAT_ADD(1'b1)) dut_sat (
        .clk(clk), .resetn(resetn), .in_valid(b_valid), .in_ready(s_ready), .in_op(b_op),
        .in_addr(b_addr), .in_data(b_data), .out_valid(s_ovalid), .out_data(s_odata),
        .init_done(s_done));

    reg_rmw_bram #(.L2_DEPTH(4), .WIDTH(8), .INIT_VAL(8'd0), .RET_NEW(1'b1), .SAT_ADD(1'b0)) dut_wrap (
        .clk(clk), .resetn(resetn), .in_valid(b_valid), .in_ready(w_ready), .in_op(b_op),
        .in_addr(b_addr), .in_data(b_data), .out_valid(w_ovalid), .out_data(w_odata),
        .init_done(w_done));

    typedef struct { logic [15:0] data; int due; } exp_t;
    typedef struct { logic [7:0]  data; int due; } exp8_t;
    typedef struct { logic [1:0] op; logic [3:0] addr; logic [15:0] data; logic [15:0] exp; } vec_t;

    exp_t  q_m[$];
    exp8_t q_s[$];
    exp8_t q_w[$];

    int n_vec  = 0;
    int n_bad  = 0;
    int n_out  = 0;
    int n_push = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitors: pop the scoreboard on every out_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            n_out++;
            if (q_m.size() == 0) begin
                check("main unexpected out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q_m.pop_front();
                check("main out_data", {16'd0, out_data}, {16'd0, e.data});
                check("main latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp8_t e;
        if (s_ovalid === 1'b1) begin
            if (q_s.size() == 0) begin
                check("sat unexpected out_valid", {31'd0, s_ovalid}, 32'd0);
            end else begin
                e = q_s.pop_front();
                check("sat out_data", {24'd0, s_odata}, {24'd0, e.data});
                check("sat latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp8_t e;
        if (w_ovalid === 1'b1) begin
            if (q_w.size() == 0) begin
                check("wrap unexpected out_valid", {31'd0, w_ovalid}, 32'd0);
            end else begin
                e = q_w.pop_front();
                check("wrap out_data", {24'd0, w_odata}, {24'd0, e.data});
                check("wrap latency", cyc, e.due);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                        input logic [15:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = a;
        in_data  = d;
        if (op != OP_NOP) begin
            q_m.push_back('{exp, cyc + 2});
            n_push++;
        end
    endtask

    task automatic bsend(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp_s, input logic [7:0] exp_w);
        @(negedge clk);
        b_valid = 1'b1;
        b_op    = op;
        b_addr  = a;
        b_data  = d;
        q_s.push_back('{exp_s, cyc + 2});
        q_w.push_back('{exp_w, cyc + 2});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_op    = OP_NOP;
            b_valid  = 1'b0;
            b_op     = OP_NOP;
        end
    endtask

    // Called at the negedge where resetn is released; counts cycles with in_ready low.
    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("sweep cycles with in_ready low", n, 16);
        check("init_done after sweep", {31'd0, init_done}, 32'd1);
    endtask

    vec_t tbl[12];

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_data = '0;
        b_valid  = 1'b0; b_op  = OP_NOP; b_addr  = '0; b_data  = '0;

        tbl = '{
            '{OP_NOP,   4'd0, 16'h0000, 16'h0000},
            '{OP_READ,  4'd3, 16'h0000, 16'hDEAD},
            '{OP_NOP,   4'd3, 16'h0000, 16'h0000},
            '{OP_ADD,   4'd3, 16'h0001, 16'hDEAD},
            '{OP_READ,  4'd3, 16'h0000, 16'hDEAE},
            '{OP_WRITE, 4'd9, 16'h1234, 16'h0005},
            '{OP_NOP,   4'd9, 16'h0000, 16'h0000},
            '{OP_ADD,   4'd9, 16'hFFFF, 16'h1234},
            '{OP_READ,  4'd9, 16'h0000, 16'h1233},
            '{OP_ADD,   4'd0, 16'h0002, 16'h0005},
            '{OP_NOP,   4'd0, 16'h0000, 16'h0000},
            '{OP_READ,  4'd0, 16'h0000, 16'h0007}
        };

        // Reset state
        repeat (3) @(negedge clk);
        check("reset in_ready",  {31'd0, in_ready},  32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data",  {16'd0, out_data},  32'd0);
        check("reset init_done", {31'd0, init_done}, 32'd0);
        resetn = 1'b1;
        wait_ready();
        check("sat in_ready after sweep",  {31'd0, s_ready}, 32'd1);
        check("wrap in_ready after sweep", {31'd0, w_ready}, 32'd1);

        // Every entry holds INIT_VAL after the sweep
        for (int a = 0; a < 16; a++) send(OP_READ, 4'(a), 16'h0, 16'd5);
        idle(1);

        // Write then read the same entry back-to-back (forwarded)
        send(OP_WRITE, 4'd3, 16'hDEAD, 16'd5);
        send(OP_READ,  4'd3, 16'h0000, 16'hDEAD);
        idle(1);

        // Same-address ADD stream returns strictly sequential old values
        send(OP_WRITE, 4'd7, 16'h0000, 16'd5);
        for (int i = 0; i < 4; i++) send(OP_ADD, 4'd7, 16'd1, 16'(i));
        send(OP_READ, 4'd7, 16'h0000, 16'd4);
        idle(1);

        // Mixed NOP / READ / ADD table
        for (int i = 0; i < 12; i++) send(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].exp);
        idle(1);

        // Saturating vs wrapping ADD on the 8-bit instances (new value returned)
        bsend(OP_WRITE, 4'd2, 8'hF0, 8'hF0, 8'hF0);
        bsend(OP_ADD,   4'd2, 8'h20, 8'hFF, 8'h10);
        bsend(OP_READ,  4'd2, 8'h00, 8'hFF, 8'h10);
        bsend(OP_ADD,   4'd2, 8'h01, 8'hFF, 8'h11);
        idle(4);

        check("main queue drained", q_m.size(), 0);
        check("sat queue drained",  q_s.size(), 0);
        check("wrap queue drained", q_w.size(), 0);
        check("out_valid count equals non-NOP count", n_out, n_push);

        // Reset with requests in flight: no responses, sweep reruns, old data gone
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_WRITE; in_addr = 4'd3; in_data = 16'hAAAA;
        @(negedge clk);
        in_op = OP_ADD; in_addr = 4'd3; in_data = 16'h0001;
        #2;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_op    = OP_NOP;
        repeat (2) @(negedge clk);
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset in_ready",  {31'd0, in_ready},  32'd0);
        resetn = 1'b1;
        wait_ready();
        send(OP_READ, 4'd3, 16'h0, 16'd5);
        send(OP_READ, 4'd9, 16'h0, 16'd5);
        send(OP_READ, 4'd0, 16'h0, 16'd5);
        send(OP_READ, 4'd7, 16'h0, 16'd5);
        idle(4);
        check("main queue drained after reset", q_m.size(), 0);
        check("out_valid count after reset", n_out, n_push);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
